// File: rtl/gamepad_input.sv
// NES/Famicom-style serial pad reader: polls on each vsync falling edge and presents an active-low button byte.
// Optional GAMEPAD_DEBOUNCE_EN: o_in only takes a byte seen on two consecutive polls.
module gamepad_input #(
   parameter int CLK_DIV = 38,
   parameter int CNT_W   = 8
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_vsync,
   input  logic       i_pad_data,
   output logic       o_pad_latch,
   output logic       o_pad_clk,
   output logic [7:0] o_in,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      READ   = 3'd2,
      CLK_HI = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(2*CLK_DIV-1);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV-1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       bit_idx, bit_d;
   logic [7:0]       shreg, shreg_d;
   logic [7:0]       in_d;
   logic             vsync_q;
   logic [1:0]       sync_q;
   logic             data_s;
   logic             start;

`ifdef GAMEPAD_DEBOUNCE_EN
   logic [7:0]       last_poll, last_d;
`endif

   assign data_s = sync_q[1];
   assign start  = vsync_q & ~i_vsync;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      bit_d   = bit_idx;
      shreg_d = shreg;
      in_d    = o_in;
`ifdef GAMEPAD_DEBOUNCE_EN
      last_d  = last_poll;
`endif
      case (state)
         IDLE: begin
            // Edges arriving mid-poll never reach here, so they are dropped rather than queued.
            if (start) begin
               state_d = LATCH;
               cnt_d   = LATCH_LOAD;
            end
         end
         LATCH: begin
            if (cnt == '0) begin
               state_d = READ;
               cnt_d   = HALF_LOAD;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         READ: begin
            if (cnt == '0) begin
               shreg_d = {shreg[6:0], data_s};
               if (bit_idx == 3'd7) begin
                  state_d = DONE;
               end else begin
                  bit_d   = bit_idx + 3'd1;
                  state_d = CLK_HI;
                  cnt_d   = HALF_LOAD;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         CLK_HI: begin
            if (cnt == '0) begin
               state_d = READ;
               cnt_d   = HALF_LOAD;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         DONE: begin
`ifdef GAMEPAD_DEBOUNCE_EN
            if (shreg == last_poll) in_d = shreg;
            last_d = shreg;
`else
            in_d = shreg;
`endif
            bit_d   = 3'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pad-facing outputs are decoded from the next state so they toggle on the same edge as the state.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= 3'd0;
         shreg       <= 8'hFF;
         o_in        <= 8'hFF;
         vsync_q     <= 1'b1;
         sync_q      <= 2'b11;
         o_pad_latch <= 1'b0;
         o_pad_clk   <= 1'b0;
         o_busy      <= 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
         last_poll   <= 8'hFF;
`endif
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         bit_idx     <= bit_d;
         shreg       <= shreg_d;
         o_in        <= in_d;
         vsync_q     <= i_vsync;
         sync_q      <= {sync_q[0], i_pad_data};
         o_pad_latch <= (state_d == LATCH);
         o_pad_clk   <= (state_d == CLK_HI);
         o_busy      <= (state_d != IDLE);
`ifdef GAMEPAD_DEBOUNCE_EN
         last_poll   <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_gamepad_input.sv
// Directed bench for gamepad_input with a behavioural NES pad shift-register model (CLK_DIV=4).
module tb_gamepad_input;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b1;
   logic       pad_data;
   logic       pad_latch, pad_clk, busy;
   logic [7:0] in_byte;

   logic [7:0] pad_bits = 8'hFF;
   int         pad_idx = 8;
   logic       pad_clk_d = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   gamepad_input #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_vsync    (vsync),
      .i_pad_data (pad_data),
      .o_pad_latch(pad_latch),
      .o_pad_clk  (pad_clk),
      .o_in       (in_byte),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   // Pad: latch reloads to button A; each pad_clk rising edge advances one button; past the end reads high.
   always @(negedge clk) begin
      if (pad_latch) pad_idx <= 0;
      else if (pad_clk && !pad_clk_d && pad_idx < 8) pad_idx <= pad_idx + 1;
      pad_clk_d <= pad_clk;
   end
   always_comb begin
      pad_data = 1'b1;
      if (pad_idx < 8) pad_data = pad_bits[7 - pad_idx];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Runs one poll; dbl drops vsync again 20 cycles in to check that a mid-poll edge is ignored.
   task automatic poll(input logic [7:0] pad, input bit dbl,
                       output int lat, output int lrise, output int lcyc,
                       output int np, output int wmin, output int wmax);
      int  cur;
      logic pl, pc;
      pad_bits = pad;
      vsync = 1'b0;
      tick(1);
      lat = -1; lrise = int'(pad_latch); lcyc = int'(pad_latch);
      np = 0; wmin = 999; wmax = 0; cur = 0;
      pl = pad_latch; pc = pad_clk;
      for (int k = 1; k <= 200; k++) begin
         if (k == 2) vsync = 1'b1;
         if (dbl && k == 20) vsync = 1'b0;
         if (dbl && k == 22) vsync = 1'b1;
         tick(1);
         if (pad_latch) begin
            lcyc++;
            if (!pl) lrise++;
         end
         if (pad_clk) begin
            if (!pc) np++;
            cur++;
         end else if (pc) begin
            if (cur < wmin) wmin = cur;
            if (cur > wmax) wmax = cur;
            cur = 0;
         end
         pl = pad_latch; pc = pad_clk;
         if (!busy) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat, lrise, lcyc, np, wmin, wmax;

   initial begin
      tick(3);
      rst = 1'b0;
      chk("reset_state", {21'd0, pad_latch, pad_clk, busy, in_byte}, {21'd0, 3'b000, 8'hFF});

      // Idle with vsync high: nothing moves.
      begin
         logic bad;
         bad = 1'b0;
         for (int i = 0; i < 200; i++) begin
            tick(1);
            if (pad_latch || pad_clk || busy || in_byte !== 8'hFF) bad = 1'b1;
         end
         chk("idle_200", {31'd0, bad}, 32'd0);
      end

`ifdef GAMEPAD_DEBOUNCE_EN
      poll(8'h7F, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("db_poll1_lat", lat, 69);
      chk("db_poll1_in", {24'd0, in_byte}, 32'hFF);
      tick(2);
      poll(8'hBF, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("db_poll2_in", {24'd0, in_byte}, 32'hFF);
      tick(2);
      poll(8'hBF, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("db_poll3_in", {24'd0, in_byte}, 32'hBF);
`else
      // A + Start pressed.
      poll(8'h6F, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("p1_latency", lat, 69);
      chk("p1_latch_rise", lrise, 1);
      chk("p1_latch_cyc", lcyc, 8);
      chk("p1_pulses", np, 7);
      chk("p1_wmin", wmin, 4);
      chk("p1_wmax", wmax, 4);
      chk("p1_in", {24'd0, in_byte}, 32'h6F);
      tick(5);
      chk("hold_between", {24'd0, in_byte}, 32'h6F);

      // Mid-poll vsync edge ignored, then an immediate new poll.
      poll(8'hDB, 1'b1, lat, lrise, lcyc, np, wmin, wmax);
      chk("p2_latency", lat, 69);
      chk("p2_latch_rise", lrise, 1);
      chk("p2_pulses", np, 7);
      chk("p2_in", {24'd0, in_byte}, 32'hDB);
      poll(8'h6F, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("p3_back2back_rise", lrise, 1);
      chk("p3_latency", lat, 69);
      chk("p3_in", {24'd0, in_byte}, 32'h6F);

      // Reset while the pad clock is high.
      tick(2);
      pad_bits = 8'h00;
      vsync = 1'b0;
      tick(2);
      vsync = 1'b1;
      begin
         int w;
         w = 0;
         while (!pad_clk && w < 100) begin
            tick(1);
            w++;
         end
         chk("rst_reach_clkhi", {31'd0, pad_clk}, 32'd1);
      end
      rst = 1'b1;
      tick(1);
      chk("rst_midpoll", {21'd0, pad_latch, pad_clk, busy, in_byte}, {21'd0, 3'b000, 8'hFF});
      rst = 1'b0;
      tick(2);
      poll(8'h6F, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("post_rst_latency", lat, 69);
      chk("post_rst_pulses", np, 7);
      chk("post_rst_in", {24'd0, in_byte}, 32'h6F);

      // Disconnected pad, then Right only.
      tick(2);
      poll(8'hFF, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("open_pad_in", {24'd0, in_byte}, 32'hFF);
      tick(2);
      poll(8'hFE, 1'b0, lat, lrise, lcyc, np, wmin, wmax);
      chk("right_in", {24'd0, in_byte}, 32'hFE);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gamepad_input.md
Name: gamepad_input

Overview:
- Upstream feeder for the CPU core's 8-bit input port (`i_in`). Drives an NES/Famicom-style serial controller (latch, clock, data) and deserialises one byte per poll.
- Each poll is triggered by the falling edge of the CPU's vsync output bit.
- Presents the active-low button byte (bit7 A … bit0 Right) as a stable register that changes only when a poll completes.
- Runs on the CPU clock; no clock-domain crossing except the pad data pin.

Parameters:
- CLK_DIV, 38: half-period of the pad clock in `i_clock` cycles (about 6 us at 6.25 MHz); must be ≥ 2.
- CNT_W, 8: width of the phase counter; must satisfy 2^CNT_W > 2*CLK_DIV.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_vsync  input  1  CPU output bit 7, active low, same clock domain; falling edge starts a poll.
- i_pad_data  input  1  serial data from pad, active low, asynchronous.
- o_pad_latch  output  1  pad latch/strobe, active high.
- o_pad_clk  output  1  pad shift clock, active high.
- o_in  output  8  button byte for the CPU input port, active low (0 = pressed).
- o_busy  output  1  high while a poll is in progress.

Behaviour:
- Reset values: `o_pad_latch`=0, `o_pad_clk`=0, `o_in`=8'hFF, `o_busy`=0, state=IDLE, bit index=0, counter=0, vsync history=1, data synchroniser=2'b11.
- `i_pad_data` passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Trigger detection:
  - A start is detected when the registered previous `i_vsync`=1 and the current `i_vsync`=0.
  - A start detected while not IDLE is ignored; it is not queued.
- State machine (one-hot or encoded, registered outputs):
  - IDLE: `o_busy`=0. On start, go to LATCH and load counter=2*CLK_DIV-1.
  - LATCH: `o_pad_latch`=1 for exactly 2*CLK_DIV cycles. When counter reaches 0, go to READ and load counter=CLK_DIV-1.
  - READ: `o_pad_latch`=0, `o_pad_clk`=0 for CLK_DIV cycles. On the last cycle, shift the synchronised data into the shift register, MSB first: `shreg <= {shreg[6:0], data}`.
    - If bit index=7, go to DONE.
    - Otherwise increment the bit index, go to CLK_HI and load counter=CLK_DIV-1.
  - CLK_HI: `o_pad_clk`=1 for CLK_DIV cycles, then return to READ.
  - DONE: one cycle. Update `o_in` from the shift register, clear the bit index, go to IDLE.
- Poll shape:
  - Exactly 7 pad clock pulses per poll.
  - The first sampled bit (button A) lands in bit 7; the last (Right) lands in bit 0.
- Latency: `o_in` changes at the clock edge exactly 17*CLK_DIV+1 cycles after the edge on which `o_pad_latch` rises. `o_pad_latch` rises on the edge that samples the vsync falling edge.
- `o_busy` is 1 in LATCH, READ, CLK_HI and DONE.
- `o_in` is never partially updated. Between polls it holds its value.
- A reset mid-poll aborts immediately:
  - all outputs return to their reset values on that edge;
  - the shift register contents are discarded.
- A disconnected pad (data pulled high) reads as 8'hFF.

Optional Feature:
- Macro: `GAMEPAD_DEBOUNCE_EN`.
- Defined:
  - An extra 8-bit register `last_poll` (reset 8'hFF) holds the previous poll's raw byte.
  - In DONE, `o_in` is updated only if the new byte equals `last_poll`. `last_poll` is always updated.
  - Any change therefore needs two consecutive identical polls.
  - Latency of a stable change is two polls.
- Not defined: `o_in` takes every completed poll directly, as described above.

Test Plan (CLK_DIV=4, debounce off unless stated):
- Reset then idle, `i_vsync` held high for 200 cycles -> `o_pad_latch`=0, `o_pad_clk`=0, `o_in`=8'hFF, `o_busy`=0 throughout.
- Falling edge of `i_vsync`; pad model returns A and Start pressed -> latch high for 8 cycles; 7 clk pulses 4 cycles wide; `o_in`=8'h6F exactly 69 cycles after latch rise.
- Second `i_vsync` falling edge at cycle 20 of an active poll -> ignored; exactly one latch pulse; result unchanged; the next edge after `o_busy` falls starts a new poll.
- Reset asserted mid-poll during CLK_HI -> next edge shows `o_pad_clk`=0, `o_busy`=0, `o_in`=8'hFF; a subsequent vsync edge gives a full, correct 69-cycle poll.
- Pad data tied high -> `o_in` stays 8'hFF; pad pressing Right only -> `o_in`=8'hFE.
- With `GAMEPAD_DEBOUNCE_EN`: polls return 8'h7F, 8'hBF, 8'hBF -> `o_in` stays FF, stays FF, then becomes 8'hBF after the third poll.
